// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
// Bundles the writeback stage's bus signals: ALU result input, load
// issue/response handshake, register-file write port and hazard scoreboard.
//   master : core side (decode/ALU/data memory); drives alu_*, ld_issue,
//            ld_rd, ld_resp_*; observes ld_ready, we/rd/data_in, busy,
//            resp_err.
//   slave  : writeback_unit; the reverse directions.
// ---------------------------------------------------------------------------
interface writeback_unit_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data_in;
    logic [31:0] busy;
    logic        resp_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_rd, ld_resp_valid, ld_resp_data,
        input  ld_ready, we, rd, data_in, busy, resp_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_rd, ld_resp_valid, ld_resp_data,
        output ld_ready, we, rd, data_in, busy, resp_err
    );
endinterface

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Writeback stage of the RV32I core and sole driver of the register-file
// write port. ALU results take priority; loads are held in a circular queue
// (allocated at issue, filled in order by memory responses, retired in order
// on cycles without an ALU result).
// Ports:
//   clk   : core clock, rising edge
//   rstN  : asynchronous active-low reset
//   bus   : writeback_unit_if.slave (ALU result, load issue/response,
//           we/rd/data_in write port, busy scoreboard, resp_err)
// Parameter:
//   DEPTH : load queue entries, power of two, 2..16
// ---------------------------------------------------------------------------
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    writeback_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]    r_head;
    logic [AW:0]    r_fill;
    logic [AW:0]    r_tail;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_filled;
    logic [4:0]     r_q_rd   [DEPTH];
    logic [31:0]    r_q_data [DEPTH];

    logic           r_we;
    logic [4:0]     r_rd;
    logic [31:0]    r_data;
    logic           r_resp_err;

    logic [AW-1:0]  w_head_idx;
    logic [AW-1:0]  w_fill_idx;
    logic [AW-1:0]  w_tail_idx;
    logic           w_full;
    logic           w_alloc;
    logic           w_fill;
    logic           w_retire;
    logic [4:0]     w_head_rd;
    logic [31:0]    w_head_data;
    logic [31:0]    w_busy;

    assign w_head_idx  = r_head[AW-1:0];
    assign w_fill_idx  = r_fill[AW-1:0];
    assign w_tail_idx  = r_tail[AW-1:0];
    assign w_full      = ((r_tail - r_head) == FULL_CNT);
    assign w_alloc     = bus.ld_issue && !w_full;
    // Only entries that existed before this edge can receive data, so a
    // response in the same cycle as the matching issue is an error.
    assign w_fill      = bus.ld_resp_valid && (r_fill != r_tail);
    assign w_retire    = !bus.alu_valid && r_valid[w_head_idx] && r_filled[w_head_idx];
    assign w_head_rd   = r_q_rd[w_head_idx];
    assign w_head_data = r_q_data[w_head_idx];

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_q_rd[i] != 5'd0)) begin
                w_busy[r_q_rd[i]] = 1'b1;
            end
        end
    end

    // Queue control and write-port registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_valid    <= '0;
            r_filled   <= '0;
            r_we       <= 1'b0;
            r_rd       <= 5'd0;
            r_data     <= 32'd0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_retire) begin
                r_valid[w_head_idx]  <= 1'b0;
                r_filled[w_head_idx] <= 1'b0;
                r_head               <= r_head + 1'b1;
            end
            if (w_fill) begin
                r_filled[w_fill_idx] <= 1'b1;
                r_fill               <= r_fill + 1'b1;
            end else if (bus.ld_resp_valid) begin
                r_resp_err <= 1'b1;
            end
            if (w_alloc) begin
                r_valid[w_tail_idx]  <= 1'b1;
                r_filled[w_tail_idx] <= 1'b0;
                r_tail               <= r_tail + 1'b1;
            end

            if (bus.alu_valid) begin
                r_we   <= (bus.alu_rd != 5'd0);
                r_rd   <= bus.alu_rd;
                r_data <= bus.alu_data;
            end else if (w_retire) begin
                r_we   <= (w_head_rd != 5'd0);
                r_rd   <= w_head_rd;
                r_data <= w_head_data;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    // Entry payload needs no reset: it is qualified by r_valid/r_filled.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_q_rd[w_tail_idx] <= bus.ld_rd;
        end
        if (w_fill) begin
            r_q_data[w_fill_idx] <= bus.ld_resp_data;
        end
    end

    assign bus.ld_ready = !w_full;
    assign bus.we       = r_we;
    assign bus.rd       = r_rd;
    assign bus.data_in  = r_data;
    assign bus.busy     = w_busy;
    assign bus.resp_err = r_resp_err;
endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
// Scoreboard bench for writeback_unit. The driver applies stimulus one cycle
// at a time and advances a reference model (a queue of pending loads plus
// the ALU-first retire rule); every register-file write the model predicts
// is pushed with its cycle number into exp_q. A separate monitor pops and
// compares on every cycle the DUT asserts we.
// ---------------------------------------------------------------------------
module tb_writeback_unit;
    localparam int DEPTH = 4;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  rd;
        logic        filled;
        logic [31:0] data;
    } ld_t;

    logic clk;
    logic rstN;
    writeback_unit_if bus();

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    wr_t  exp_q[$];
    ld_t  m_q[$];
    logic m_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (m_q[i]) if (m_q[i].rd != 5'd0) b[m_q[i].rd] = 1'b1;
        return b;
    endfunction

    function automatic bit model_has_unfilled();
        foreach (m_q[i]) if (!m_q[i].filled) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the reference model, evaluated on pre-edge state.
    task automatic model_edge(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic li, input logic [4:0] lrd,
                              input logic rv, input logic [31:0] rdat);
        int  f;
        bit  do_ret;
        bit  do_alloc;
        ld_t e;
        f = -1;
        for (int i = 0; i < m_q.size(); i++) begin
            if (!m_q[i].filled) begin
                f = i;
                break;
            end
        end
        do_ret   = !av && (m_q.size() > 0) && m_q[0].filled;
        do_alloc = li && (m_q.size() < DEPTH);
        if (av && ard != 5'd0) exp_q.push_back('{cyc, ard, ad});
        if (rv) begin
            if (f >= 0) begin
                m_q[f].filled = 1'b1;
                m_q[f].data   = rdat;
            end else begin
                m_err = 1'b1;
            end
        end
        if (do_ret) begin
            e = m_q.pop_front();
            if (e.rd != 5'd0) exp_q.push_back('{cyc, e.rd, e.data});
        end
        if (do_alloc) m_q.push_back('{lrd, 1'b0, 32'd0});
    endtask

    // Entered and left at a falling edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic li, input logic [4:0] lrd,
                        input logic rv, input logic [31:0] rdat);
        bus.alu_valid     = av;
        bus.alu_rd        = ard;
        bus.alu_data      = ad;
        bus.ld_issue      = li;
        bus.ld_rd         = lrd;
        bus.ld_resp_valid = rv;
        bus.ld_resp_data  = rdat;
        @(posedge clk);
        cyc++;
        model_edge(av, ard, ad, li, lrd, rv, rdat);
        @(negedge clk);
        chk("busy",     bus.busy, model_busy());
        chk("ld_ready", 32'(bus.ld_ready), 32'(m_q.size() < DEPTH));
        chk("resp_err", 32'(bus.resp_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        step(1, r, d, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] r);
        step(0, 0, 0, 1, r, 0, 0);
    endtask

    task automatic resp(input logic [31:0] d);
        step(0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},       32'(bus.we), 32'd0);
        chk({tag, "_rd"},       32'(bus.rd), 32'd0);
        chk({tag, "_data_in"},  bus.data_in, 32'd0);
        chk({tag, "_busy"},     bus.busy, 32'd0);
        chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd1);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    endtask

    // Monitor: every DUT write must match the oldest predicted write, including its cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rstN && bus.we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write (cycle %0d)",
                             bus.rd, bus.data_in, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wr_rd",    32'(bus.rd), 32'(e.rd));
                    chk("wr_data",  bus.data_in, e.data);
                end
            end
        end
    end

    initial begin
        logic        av, li, rv;
        logic [4:0]  ard, lrd;
        logic [31:0] ad, rdat;

        rstN              = 1'b0;
        bus.alu_valid     = 1'b0;
        bus.alu_rd        = 5'd0;
        bus.alu_data      = 32'd0;
        bus.ld_issue      = 1'b0;
        bus.ld_rd         = 5'd0;
        bus.ld_resp_valid = 1'b0;
        bus.ld_resp_data  = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rstN = 1'b1;

        // ALU path, including a write to x0 that must not assert we.
        alu(5'd5, 32'hDEADBEEF);
        alu(5'd0, 32'h11111111);
        idle(2);

        // Load path: busy[7] while queued, write two cycles after response.
        issue(5'd7);
        idle(1);
        resp(32'h12345678);
        idle(3);

        // Contention: ALU results in the two cycles after the response go first.
        issue(5'd9);
        idle(1);
        resp(32'hCAFE0009);
        alu(5'd3, 32'h00000003);
        alu(5'd4, 32'h00000004);
        idle(3);

        // Full and wrap.
        for (int i = 1; i <= DEPTH; i++) issue(5'(i));
        issue(5'd20);
        for (int i = 1; i <= DEPTH; i++) resp(32'hA0000000 + 32'(i));
        idle(3);
        for (int i = 8; i < 8 + DEPTH; i++) issue(5'(i));
        for (int i = 8; i < 8 + DEPTH; i++) resp(32'hB0000000 + 32'(i));
        idle(3);

        // Errors: response to an empty queue, then a load to x0.
        resp(32'hBAD0BAD0);
        issue(5'd0);
        idle(1);
        resp(32'h0000F00D);
        idle(3);

        // Reset mid-run with two loads queued.
        issue(5'd12);
        issue(5'd13);
        idle(1);
        #2 rstN = 1'b0;
        #1 check_reset_outputs("mid");
        m_q.delete();
        exp_q.delete();
        m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        idle(6);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            av   = ($urandom_range(3) == 0);
            ard  = 5'($urandom);
            ad   = $urandom;
            li   = ($urandom_range(2) == 0);
            lrd  = 5'($urandom);
            rv   = model_has_unfilled() && ($urandom_range(1) == 0);
            rdat = $urandom;
            step(av, ard, ad, li, lrd, rv, rdat);
        end

        // Drain: answer outstanding loads, then let everything retire.
        for (int n = 0; n < 4 * DEPTH && model_has_unfilled(); n++) resp($urandom);
        idle(2 * DEPTH + 4);
        chk("drain_pending_writes", 32'(exp_q.size()), 32'd0);
        chk("drain_queue_empty",    32'(m_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
